// File: rtl/midi_pkg.sv
// midi_pkg: shared types and helpers for the MIDI byte parser.
//   midi_state_e  : parser FSM states (ST_SYSEX exists only with MIDI_SYSEX_EN)
//   STAT_MIN      : lowest status byte (0x80)
//   SYSEX_START   : system exclusive start (0xF0)
//   SYSEX_END     : system exclusive end (0xF7)
//   RT_MIN        : lowest realtime byte (0xF8)
//   midi_data_len : data bytes following a channel status byte (0..2)
// Optional feature macro: MIDI_SYSEX_EN
package midi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1
`ifdef MIDI_SYSEX_EN
    ,ST_SYSEX = 2'd2
`endif
  } midi_state_e;

  localparam logic [7:0] STAT_MIN    = 8'h80;
  localparam logic [7:0] SYSEX_START = 8'hF0;
  localparam logic [7:0] SYSEX_END   = 8'hF7;
  localparam logic [7:0] RT_MIN      = 8'hF8;

  function automatic logic [1:0] midi_data_len(input logic [7:0] status);
    case (status[7:4])
      4'hC, 4'hD:                   return 2'd1;
      4'h8, 4'h9, 4'hA, 4'hB, 4'hE: return 2'd2;
      default:                      return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/midi_rx_timeout.sv
// midi_rx_timeout: idle counter for the MIDI parser.
//   reg_clk     : clock
//   reset_reg_N : async active-low reset
//   rx_valid    : received-byte strobe, clears the counter
//   expire      : one-cycle pulse on the edge the counter reaches IDLE_TIMEOUT
// The counter saturates, so expire fires once per idle gap. A byte arriving
// in the firing cycle suppresses the pulse. IDLE_TIMEOUT must be >= 1.
module midi_rx_timeout #(
  parameter int IDLE_TIMEOUT = 50000
) (
  input  logic reg_clk,
  input  logic reset_reg_N,
  input  logic rx_valid,
  output logic expire
);

  localparam int CW = (IDLE_TIMEOUT < 2) ? 1 : $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(IDLE_TIMEOUT);
  localparam logic [CW-1:0] LAST  = CW'(IDLE_TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // Expire on the transition into the saturated value only.
  assign expire = !rx_valid && (cnt == LAST);

  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N)      cnt <= '0;
    else if (rx_valid)     cnt <= '0;
    else if (cnt != LIMIT) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/midi_byte_parser.sv
// midi_byte_parser: MIDI byte stream parser with running status.
//   reg_clk, reset_reg_N : clock, async active-low reset
//   rx_valid/rx_byte/rx_err : received byte strobe, data, framing error
//   byteready    : one-cycle pulse, cur_status/midibyte_nr/midi_in_data valid
//   cur_status   : current running status (0x00 when none)
//   midibyte_nr  : byte index in message, status byte = 0
//   midi_in_data : forwarded byte
//   rt_valid/rt_byte : realtime byte pulse and value
// All outputs registered, one cycle after rx_valid.
// Optional feature macro: MIDI_SYSEX_EN (system exclusive forwarding).
module midi_byte_parser
  import midi_pkg::*;
#(
  parameter int IDLE_TIMEOUT = 50000
) (
  input  logic       reg_clk,
  input  logic       reset_reg_N,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  input  logic       rx_err,
  output logic       byteready,
  output logic [7:0] cur_status,
  output logic [7:0] midibyte_nr,
  output logic [7:0] midi_in_data,
  output logic       rt_valid,
  output logic [7:0] rt_byte
);

  midi_state_e state, state_n;
  logic [7:0]  cur_n, nr_n, data_n, rtb_n;
  logic        br_n, rt_n, expire;
  logic [1:0]  len;

  midi_rx_timeout #(.IDLE_TIMEOUT(IDLE_TIMEOUT)) u_timeout (
    .reg_clk     (reg_clk),
    .reset_reg_N (reset_reg_N),
    .rx_valid    (rx_valid),
    .expire      (expire)
  );

  assign len = midi_data_len(cur_status);

  always_comb begin
    state_n = state;
    cur_n   = cur_status;
    nr_n    = midibyte_nr;
    data_n  = midi_in_data;
    rtb_n   = rt_byte;
    br_n    = 1'b0;
    rt_n    = 1'b0;
    // IDLE never holds a status; this also clears the 0xF0 left visible
    // for the closing 0xF7 pulse of a sysex message.
    if (state == ST_IDLE) cur_n = 8'h00;
    if (rx_valid) begin
      if (rx_err) begin
        state_n = ST_IDLE;
        cur_n   = 8'h00;
        nr_n    = 8'h00;
      end else if (rx_byte >= RT_MIN) begin
        rt_n  = 1'b1;
        rtb_n = rx_byte;
      end else if (rx_byte < STAT_MIN) begin
        case (state)
          ST_RUN: begin
            // Past the last data byte, running status restarts at 1.
            nr_n   = (midibyte_nr >= {6'd0, len}) ? 8'd1 : midibyte_nr + 8'd1;
            data_n = rx_byte;
            br_n   = 1'b1;
          end
`ifdef MIDI_SYSEX_EN
          ST_SYSEX: begin
            nr_n   = (midibyte_nr == 8'hFF) ? 8'hFF : midibyte_nr + 8'd1;
            data_n = rx_byte;
            br_n   = 1'b1;
          end
`endif
          default: ;
        endcase
      end else if (rx_byte < SYSEX_START) begin
        state_n = ST_RUN;
        cur_n   = rx_byte;
        nr_n    = 8'h00;
        data_n  = rx_byte;
        br_n    = 1'b1;
      end
`ifdef MIDI_SYSEX_EN
      else if (rx_byte == SYSEX_START) begin
        state_n = ST_SYSEX;
        cur_n   = rx_byte;
        nr_n    = 8'h00;
        data_n  = rx_byte;
        br_n    = 1'b1;
      end else if (rx_byte == SYSEX_END && state == ST_SYSEX) begin
        // Forwarded with status still 0xF0; IDLE clears it next cycle.
        state_n = ST_IDLE;
        nr_n    = (midibyte_nr == 8'hFF) ? 8'hFF : midibyte_nr + 8'd1;
        data_n  = rx_byte;
        br_n    = 1'b1;
      end
`endif
      else begin
        state_n = ST_IDLE;
        cur_n   = 8'h00;
      end
    end else if (expire) begin
      case (state)
        ST_RUN: nr_n = 8'h00;
`ifdef MIDI_SYSEX_EN
        ST_SYSEX: begin
          state_n = ST_IDLE;
          cur_n   = 8'h00;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      state        <= ST_IDLE;
      cur_status   <= 8'h00;
      midibyte_nr  <= 8'h00;
      midi_in_data <= 8'h00;
      rt_byte      <= 8'h00;
      byteready    <= 1'b0;
      rt_valid     <= 1'b0;
    end else begin
      state        <= state_n;
      cur_status   <= cur_n;
      midibyte_nr  <= nr_n;
      midi_in_data <= data_n;
      rt_byte      <= rtb_n;
      byteready    <= br_n;
      rt_valid     <= rt_n;
    end
  end

endmodule

// File: tb/tb_midi_byte_parser.sv
// tb_midi_byte_parser: directed self-checking bench for midi_byte_parser.
// Runs with a short IDLE_TIMEOUT; sysex checks follow MIDI_SYSEX_EN.
module tb_midi_byte_parser;

  localparam int TO = 8;

  logic       reg_clk = 1'b0;
  logic       reset_reg_N = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_err = 1'b0;
  logic       byteready, rt_valid;
  logic [7:0] cur_status, midibyte_nr, midi_in_data, rt_byte;

  int checks = 0;
  int errors = 0;

  midi_byte_parser #(.IDLE_TIMEOUT(TO)) dut (
    .reg_clk      (reg_clk),
    .reset_reg_N  (reset_reg_N),
    .rx_valid     (rx_valid),
    .rx_byte      (rx_byte),
    .rx_err       (rx_err),
    .byteready    (byteready),
    .cur_status   (cur_status),
    .midibyte_nr  (midibyte_nr),
    .midi_in_data (midi_in_data),
    .rt_valid     (rt_valid),
    .rt_byte      (rt_byte)
  );

  always #5 reg_clk = ~reg_clk;

  // Present a byte for one edge; outputs are sampled on the following negedge.
  task automatic send(input logic [7:0] b, input logic err);
    rx_valid = 1'b1; rx_byte = b; rx_err = err;
    @(negedge reg_clk);
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0; rx_err = 1'b0;
    repeat (n) @(negedge reg_clk);
  endtask

  task automatic test_reset;
    idle(2);
    checks++;
    if ({byteready, rt_valid, cur_status, midibyte_nr, midi_in_data, rt_byte} !== 34'd0) begin
      errors++;
      $display("FAIL reset_state: got br=%b rt=%b st=%h nr=%h d=%h rb=%h want all 0",
               byteready, rt_valid, cur_status, midibyte_nr, midi_in_data, rt_byte);
    end
    reset_reg_N = 1'b1;
    send(8'h90, 1'b0);
    checks++;
    if (byteready !== 1'b1 || cur_status !== 8'h90) begin
      errors++;
      $display("FAIL first_after_reset: got br=%b st=%h want br=1 st=90", byteready, cur_status);
    end
    send(8'h3C, 1'b0);
    idle(1);
    reset_reg_N = 1'b0;
    #1;
    checks++;
    if (cur_status !== 8'h00 || midibyte_nr !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: got st=%h nr=%h want 00 00", cur_status, midibyte_nr);
    end
    @(negedge reg_clk);
    reset_reg_N = 1'b1;
    send(8'h40, 1'b0);
    checks++;
    if (byteready !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard: got br=%b want 0", byteready);
    end
    idle(2);
  endtask

  task automatic test_note_on;
    logic [7:0] b [5] = '{8'h90, 8'h3C, 8'h64, 8'h40, 8'h00};
    logic [7:0] n [5] = '{8'd0, 8'd1, 8'd2, 8'd1, 8'd2};
    for (int i = 0; i < 5; i++) begin
      send(b[i], 1'b0);
      checks++;
      if (byteready !== 1'b1 || midibyte_nr !== n[i] || cur_status !== 8'h90 || midi_in_data !== b[i]) begin
        errors++;
        $display("FAIL note_on[%0d]: got br=%b nr=%h st=%h d=%h want br=1 nr=%h st=90 d=%h",
                 i, byteready, midibyte_nr, cur_status, midi_in_data, n[i], b[i]);
      end
    end
    idle(2);
  endtask

  task automatic test_prog_change;
    logic [7:0] b [3] = '{8'hC2, 8'h05, 8'h07};
    logic [7:0] n [3] = '{8'd0, 8'd1, 8'd1};
    for (int i = 0; i < 3; i++) begin
      send(b[i], 1'b0);
      checks++;
      if (byteready !== 1'b1 || midibyte_nr !== n[i] || midi_in_data !== b[i] || cur_status !== 8'hC2) begin
        errors++;
        $display("FAIL prog_change[%0d]: got br=%b nr=%h d=%h st=%h want br=1 nr=%h d=%h st=c2",
                 i, byteready, midibyte_nr, midi_in_data, cur_status, n[i], b[i]);
      end
    end
    idle(2);
  endtask

  task automatic test_realtime;
    logic [7:0] b [4] = '{8'h90, 8'h3C, 8'hF8, 8'h64};
    logic       e [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0] n [4] = '{8'd0, 8'd1, 8'd1, 8'd2};
    int rt_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      send(b[i], 1'b0);
      if (rt_valid === 1'b1) rt_cnt++;
      checks++;
      if (byteready !== e[i] || midibyte_nr !== n[i] || cur_status !== 8'h90) begin
        errors++;
        $display("FAIL realtime[%0d]: got br=%b nr=%h st=%h want br=%b nr=%h st=90",
                 i, byteready, midibyte_nr, cur_status, e[i], n[i]);
      end
      if (i == 2) begin
        checks++;
        if (rt_valid !== 1'b1 || rt_byte !== 8'hF8) begin
          errors++;
          $display("FAIL rt_pulse: got rt=%b rb=%h want rt=1 rb=f8", rt_valid, rt_byte);
        end
      end
    end
    checks++;
    if (rt_cnt != 1) begin
      errors++;
      $display("FAIL rt_count: got %0d want 1", rt_cnt);
    end
    idle(2);
  endtask

  task automatic test_timeout;
    send(8'h90, 1'b0);
    send(8'h3C, 1'b0);
    idle(TO);
    checks++;
    if (midibyte_nr !== 8'h00 || cur_status !== 8'h90) begin
      errors++;
      $display("FAIL timeout_run: got nr=%h st=%h want nr=00 st=90", midibyte_nr, cur_status);
    end
    send(8'h40, 1'b0);
    checks++;
    if (byteready !== 1'b1 || midibyte_nr !== 8'h01 || cur_status !== 8'h90) begin
      errors++;
      $display("FAIL timeout_resume: got br=%b nr=%h st=%h want br=1 nr=01 st=90",
               byteready, midibyte_nr, cur_status);
    end
    // Byte landing in the firing cycle beats the timeout.
    send(8'h90, 1'b0);
    send(8'h3C, 1'b0);
    idle(TO - 1);
    send(8'h64, 1'b0);
    checks++;
    if (byteready !== 1'b1 || midibyte_nr !== 8'h02) begin
      errors++;
      $display("FAIL timeout_race: got br=%b nr=%h want br=1 nr=02", byteready, midibyte_nr);
    end
    idle(2);
  endtask

  task automatic test_error;
    send(8'h80, 1'b0);
    checks++;
    if (byteready !== 1'b1 || cur_status !== 8'h80) begin
      errors++;
      $display("FAIL err_status: got br=%b st=%h want br=1 st=80", byteready, cur_status);
    end
    send(8'h3C, 1'b1);
    checks++;
    if (byteready !== 1'b0 || rt_valid !== 1'b0 || cur_status !== 8'h00 || midibyte_nr !== 8'h00) begin
      errors++;
      $display("FAIL err_drop: got br=%b rt=%b st=%h nr=%h want 0 0 00 00",
               byteready, rt_valid, cur_status, midibyte_nr);
    end
    send(8'h3C, 1'b0);
    checks++;
    if (byteready !== 1'b0) begin
      errors++;
      $display("FAIL err_idle_data: got br=%b want 0", byteready);
    end
    idle(2);
  endtask

  task automatic test_sys_common;
    send(8'h90, 1'b0);
    send(8'hF2, 1'b0);
    checks++;
    if (byteready !== 1'b0 || cur_status !== 8'h00) begin
      errors++;
      $display("FAIL syscommon: got br=%b st=%h want br=0 st=00", byteready, cur_status);
    end
    send(8'h3C, 1'b0);
    checks++;
    if (byteready !== 1'b0) begin
      errors++;
      $display("FAIL syscommon_data: got br=%b want 0", byteready);
    end
    idle(2);
  endtask

  task automatic test_sysex;
    logic [7:0] b [4] = '{8'hF0, 8'h7E, 8'h01, 8'hF7};
    for (int i = 0; i < 4; i++) begin
      send(b[i], 1'b0);
`ifdef MIDI_SYSEX_EN
      checks++;
      if (byteready !== 1'b1 || midibyte_nr !== 8'(i) || cur_status !== 8'hF0 || midi_in_data !== b[i]) begin
        errors++;
        $display("FAIL sysex[%0d]: got br=%b nr=%h st=%h d=%h want br=1 nr=%h st=f0 d=%h",
                 i, byteready, midibyte_nr, cur_status, midi_in_data, 8'(i), b[i]);
      end
`else
      checks++;
      if (byteready !== 1'b0) begin
        errors++;
        $display("FAIL sysex_off[%0d]: got br=%b want 0", i, byteready);
      end
`endif
    end
    idle(1);
    checks++;
    if (cur_status !== 8'h00) begin
      errors++;
      $display("FAIL sysex_end_status: got %h want 00", cur_status);
    end
`ifdef MIDI_SYSEX_EN
    send(8'hF0, 1'b0);
    send(8'h7E, 1'b0);
    idle(TO);
    send(8'h10, 1'b0);
    checks++;
    if (byteready !== 1'b0 || cur_status !== 8'h00) begin
      errors++;
      $display("FAIL sysex_timeout: got br=%b st=%h want br=0 st=00", byteready, cur_status);
    end
`endif
    idle(2);
  endtask

  initial begin
    test_reset();
    test_note_on();
    test_prog_change();
    test_realtime();
    test_timeout();
    test_error();
    test_sys_common();
    test_sysex();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/midi_byte_parser.md
MIDI_BYTE_PARSER -- requirements
Module: midi_byte_parser

Interface
REQ-001 Parameter IDLE_TIMEOUT, default 50000, is the reg_clk cycle count without rx_valid after which a partial message is abandoned.
REQ-002 Port reg_clk, input, 1: single clock; all logic is posedge reg_clk.
REQ-003 Port reset_reg_N, input, 1: reset, asynchronous assert, active-low.
REQ-004 Port rx_valid, input, 1: one-cycle strobe; rx_byte is valid this cycle.
REQ-005 Port rx_byte, input, 8: received MIDI byte.
REQ-006 Port rx_err, input, 1: framing error, qualified by rx_valid.
REQ-007 Port byteready, output, 1: one-cycle pulse; the three outputs below are valid this cycle.
REQ-008 Port cur_status, output, 8: current running status; 0x00 when none.
REQ-009 Port midibyte_nr, output, 8: byte index within the message; status byte = 0.
REQ-010 Port midi_in_data, output, 8: forwarded byte.
REQ-011 Port rt_valid, output, 1: one-cycle pulse for a realtime byte.
REQ-012 Port rt_byte, output, 8: realtime byte, valid with rt_valid.

Function
REQ-013 The block SHALL be a 3-state FSM (IDLE: no running status; RUN: running status held; SYSEX) with all outputs registered and 1-cycle latency from rx_valid; back-to-back rx_valid every cycle SHALL be accepted.
REQ-014 Channel status 0x80-0xEF in any state: cur_status=byte, midibyte_nr=0, midi_in_data=byte, byteready pulse, enter RUN.
REQ-015 Data length: 0x8n, 0x9n, 0xAn, 0xBn and 0xEn have 2 data bytes; 0xCn and 0xDn have 1.
REQ-016 Data byte (<0x80) in RUN: midibyte_nr increments; after the last data byte of the message, the next data byte SHALL restart at 1 (running status); midi_in_data=byte; byteready pulse.
REQ-017 Data byte in IDLE: discarded, no byteready.
REQ-018 0xF1-0xF6: no byteready, cur_status=0x00, enter IDLE.
REQ-019 Realtime 0xF8-0xFF in any state: rt_valid pulse with rt_byte=byte; FSM, counters and byteready unaffected.
REQ-020 rx_valid with rx_err=1: byte dropped, cur_status=0x00, midibyte_nr=0, enter IDLE, no pulses.
REQ-021 Idle counter: cleared on every rx_valid, saturates at IDLE_TIMEOUT; on reaching IDLE_TIMEOUT in RUN, midibyte_nr=0 and running status is kept; in SYSEX, enter IDLE with cur_status=0x00.
REQ-022 rx_valid in the same cycle the timeout fires: the byte wins and the timeout is ignored.

Reset
REQ-023 While reset_reg_N=0: state IDLE, byteready=0, rt_valid=0, cur_status, midibyte_nr, midi_in_data and rt_byte = 0x00, idle counter=0; reset mid-message discards the message.
REQ-024 The first rx_valid SHALL be honoured in the first reg_clk edge after reset release.

Configuration
REQ-025 With MIDI_SYSEX_EN defined: 0xF0 gives byteready with cur_status=0xF0, midibyte_nr=0 and enters SYSEX; there each data byte is forwarded with midibyte_nr incrementing and saturating at 0xFF; 0xF7 is forwarded as the last byte, then cur_status=0x00 and enter IDLE; a channel status byte aborts SYSEX per REQ-014.
REQ-026 Without MIDI_SYSEX_EN: 0xF0 and 0xF7 act as in REQ-018; the SYSEX state and its logic SHALL be absent.

Structure
REQ-027 Package midi_pkg SHALL hold: state enum, status range constants (0x80, 0xF0, 0xF7, 0xF8), and function midi_data_len(status) returning 0..2.
REQ-028 Sub-module midi_rx_timeout (idle counter, IDLE_TIMEOUT, rx_valid clear, one-cycle expire pulse) SHALL hold the timeout logic; all else is flat.

Verification
REQ-029 Bytes 0x90,0x3C,0x64,0x40,0x00 -> byteready 5x; nr 0,1,2,1,2; cur_status=0x90 throughout.
REQ-030 Bytes 0xC2,0x05,0x07 -> nr 0,1,1; data 0xC2,0x05,0x07.
REQ-031 Bytes 0x90,0x3C,0xF8,0x64 -> rt_valid once with 0xF8; byteready nr 0,1,2 unbroken.
REQ-032 Bytes 0x90,0x3C, then idle IDLE_TIMEOUT cycles, then 0x40 -> last byte nr=1, cur_status=0x90.
REQ-033 Bytes 0x80, rx_err byte, 0x3C -> one byteready only (0x80); cur_status=0x00 after the error.
REQ-034 With MIDI_SYSEX_EN, bytes 0xF0,0x7E,0x01,0xF7 -> nr 0,1,2,3; cur_status=0xF0; then 0x00. Without the macro -> no byteready.
